writeback_stage: RTL

- Final pipeline stage. Sits directly upstream of the register file and drives its write port and its ecall handshake.
- Buffers completed results from the memory stage in an in-order FIFO, then applies load sign/zero extension.
- Issues one register write per cycle and serialises ecalls: no write is issued while an ecall is outstanding.
- Keeps a retired-instruction counter.

---
 rtl/writeback_stage.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Final pipeline stage: buffers completed results, extends load data, drives the register file write port and ecall handshake.
// Latency: an entry pushed at edge N is popped at edge N+1, so its write is visible in the cycle after N+1. Sustained rate is 1 per cycle.
// Backpressure: in_ready drops only when the result FIFO is full. The FIFO stops popping while an ecall is outstanding or being released.

module writeback_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // The extra pointer MSB tells full apart from empty when the indices match.
    assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush and reset both return the FIFO to empty.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write; the caller already gates push with flush.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module writeback_stage #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_wb_en,
    input  logic            in_is_load,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_load_data,
    input  logic [1:0]      in_load_size,
    input  logic            in_load_unsigned,
    input  logic            in_is_ecall,
    input  logic            flush,
    output logic            rf_write_enable,
    output logic [4:0]      rf_write_register,
    output logic [XLEN-1:0] rf_write_value,
    output logic            rf_ecall,
    input  logic            rf_ecall_done,
    output logic            retire_valid,
    output logic [63:0]     retire_count
);
    typedef struct packed {
        logic [4:0]      rd;
        logic            wb_en;
        logic            is_load;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] load_data;
        logic [1:0]      load_size;
        logic            load_unsigned;
        logic            is_ecall;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        ECALL_WAIT    = 2'd1,
        ECALL_RELEASE = 2'd2
    } state_t;

    localparam int EW = $bits(entry_t);

    state_t          state_q;
    state_t          state_d;
    entry_t          in_entry;
    entry_t          head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            sign_bit;
    logic [XLEN-1:0] ext_value;

    assign in_ready = !fifo_full;
    // A push coinciding with flush is dropped along with the buffered entries.
    assign push     = in_valid && in_ready && !flush;

    assign in_entry = '{
        rd:            in_rd,
        wb_en:         in_wb_en,
        is_load:       in_is_load,
        alu_result:    in_alu_result,
        load_data:     in_load_data,
        load_size:     in_load_size,
        load_unsigned: in_load_unsigned,
        is_ecall:      in_is_ecall
    };

    writeback_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (push),
        .push_dat (in_entry),
        .pop      (pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Load extension of the head entry; the sign bit is the top bit of the loaded field.
    always_comb begin
        sign_bit  = 1'b0;
        ext_value = head.alu_result;
        if (head.is_load) begin
            case (head.load_size)
                2'd0: begin
                    sign_bit  = !head.load_unsigned && head.load_data[7];
                    ext_value = {{(XLEN-8){sign_bit}}, head.load_data[7:0]};
                end
                2'd1: begin
                    sign_bit  = !head.load_unsigned && head.load_data[15];
                    ext_value = {{(XLEN-16){sign_bit}}, head.load_data[15:0]};
                end
                2'd2: begin
                    sign_bit  = !head.load_unsigned && head.load_data[31];
                    ext_value = {{(XLEN-32){sign_bit}}, head.load_data[31:0]};
                end
                default: ext_value = head.load_data;
            endcase
        end
    end

    // Next state and pop decision; pops happen only in IDLE and never on a flush cycle.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !flush) begin
                    pop = 1'b1;
                    if (head.is_ecall)
                        state_d = ECALL_WAIT;
                end
            end
            ECALL_WAIT: begin
                if (rf_ecall_done)
                    state_d = ECALL_RELEASE;
            end
            ECALL_RELEASE: state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Registered register-file outputs and retirement bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_enable   <= 1'b0;
            rf_write_register <= '0;
            rf_write_value    <= '0;
            rf_ecall          <= 1'b0;
            retire_valid      <= 1'b0;
            retire_count      <= '0;
        end else begin
            rf_write_enable <= 1'b0;
            retire_valid    <= 1'b0;
            if (pop && !head.is_ecall) begin
                rf_write_enable   <= head.wb_en && (head.rd != 5'd0);
                rf_write_register <= head.rd;
                rf_write_value    <= ext_value;
                retire_valid      <= 1'b1;
                retire_count      <= retire_count + 64'd1;
            end
            if (pop && head.is_ecall)
                rf_ecall <= 1'b1;
            // The ecall retires only once the register file reports completion.
            if (state_q == ECALL_WAIT && rf_ecall_done) begin
                rf_ecall     <= 1'b0;
                retire_valid <= 1'b1;
                retire_count <= retire_count + 64'd1;
            end
        end
    end
endmodule
